mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, sitting between EX and the writeback stage. It issues word loads and stores to the data memory over a request/ready handshake and stalls the upstream pipeline while memory is busy. It owns the 64-bit MAC accumulator register. Results are held in the MEM/WB pipeline register that directly feeds writeback.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/mem_stage_mac_acc.sv | 37 +++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and widths for the RISC-V pipeline slice.
// Holds the memory-stage FSM encoding and the datapath/accumulator widths.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ACCW = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;
endpackage

// File: rtl/mem_stage_mac_acc.sv
// 64-bit MAC accumulator: clear, wrap-around add, or clear-and-load in one cycle.
// Exposes the value being written so the pipeline can capture the new sum.
module mac_acc
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            add_en,
    input  logic [ACCW-1:0] product,
    output logic [ACCW-1:0] acc_next
);
    logic [ACCW-1:0] acc_r;

    // Next accumulator value; clear together with an add leaves just the product
    always_comb begin
        acc_next = acc_r;
        if (clr && add_en) begin
            acc_next = product;
        end else if (clr) begin
            acc_next = {ACCW{1'b0}};
        end else if (add_en) begin
            acc_next = acc_r + product;
        end else begin
            acc_next = acc_r;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACCW{1'b0}};
        end else begin
            acc_r <= acc_next;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: word load/store handshake with data memory, upstream stall,
// misalignment trap, MAC accumulator and the MEM/WB pipeline register.
module mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] store_data,
    input  logic            memread,
    input  logic            memwrite,
    input  logic            memtoreg,
    input  logic            regwrite,
    input  logic            acc,
    input  logic [4:0]      rd,
    input  logic [ACCW-1:0] mac_product,
    input  logic            acc_clr,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            misalign,
    output logic            wb_valid,
    output logic            wb_memtoreg,
    output logic            wb_acc,
    output logic            wb_regwrite,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_alu_res,
    output logic [ACCW-1:0] wb_accumulator
);
    mem_state_t      state_r;
    mem_state_t      next_state_s;
    logic            mem_op_s;
    logic            bad_addr_s;
    logic            issue_s;
    logic            retire_s;
    logic            acc_add_s;
    logic [ACCW-1:0] acc_sum_s;

    assign mem_op_s   = ex_valid & (memread | memwrite);
    assign bad_addr_s = (state_r == IDLE) & mem_op_s & (alu_res[1:0] != 2'b00);
    // A request is outstanding in WAIT, or starts now for an aligned op in IDLE
    assign issue_s    = (state_r == WAIT) | (mem_op_s & (alu_res[1:0] == 2'b00));
    assign retire_s   = ~rst & ((ex_valid & ~mem_op_s) | (issue_s & dmem_ready));
    assign acc_add_s  = retire_s & ex_valid & ~mem_op_s & acc;

    assign dmem_addr  = {alu_res[XLEN-1:2], 2'b00};
    assign dmem_wdata = store_data;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s && !dmem_ready) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: memory request and upstream stall
    always_comb begin
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        mem_stall = 1'b0;
        if (rst) begin
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            mem_stall = 1'b0;
        end else begin
            case (state_r)
                IDLE, WAIT: begin
                    dmem_req  = issue_s;
                    dmem_we   = issue_s & memwrite;
                    mem_stall = issue_s & ~dmem_ready;
                end
                default: begin
                    dmem_req  = 1'b0;
                    dmem_we   = 1'b0;
                    mem_stall = 1'b0;
                end
            endcase
        end
    end

    mac_acc u_mac_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .add_en   (acc_add_s),
        .product  (mac_product),
        .acc_next (acc_sum_s)
    );

    // One-cycle misalignment error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= bad_addr_s;
        end
    end

    // MEM/WB pipeline register; only wb_valid drops when nothing retires
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_memtoreg    <= 1'b0;
            wb_acc         <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_rd          <= 5'd0;
            wb_read_data   <= {XLEN{1'b0}};
            wb_alu_res     <= {XLEN{1'b0}};
            wb_accumulator <= {ACCW{1'b0}};
        end else if (retire_s) begin
            wb_valid    <= 1'b1;
            wb_memtoreg <= memtoreg;
            wb_acc      <= acc;
            wb_regwrite <= regwrite & ~(mem_op_s & memwrite);
            wb_rd       <= rd;
            wb_alu_res  <= alu_res;
            if (mem_op_s && !memwrite) begin
                wb_read_data <= dmem_rdata;
            end
            if (acc_add_s) begin
                wb_accumulator <= acc_sum_s;
            end
        end else begin
            wb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic        memread, memwrite, memtoreg, regwrite, acc;
    logic [4:0]  rd;
    logic [63:0] mac_product;
    logic        acc_clr;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall, misalign;
    logic        wb_valid, wb_memtoreg, wb_acc, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_read_data, wb_alu_res;
    logic [63:0] wb_accumulator;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the MEM/WB register should hold
    logic        e_valid, e_mtr, e_acc, e_rw, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_rdata, e_alu;
    logic [63:0] e_accum, acc_m;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_res(alu_res),
        .store_data(store_data), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .acc(acc), .rd(rd),
        .mac_product(mac_product), .acc_clr(acc_clr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misalign(misalign),
        .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_acc(wb_acc),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_read_data(wb_read_data),
        .wb_alu_res(wb_alu_res), .wb_accumulator(wb_accumulator)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_mtr = 1'b0; e_acc = 1'b0; e_rw = 1'b0; e_mis = 1'b0;
        e_rd = 5'd0; e_rdata = 32'd0; e_alu = 32'd0; e_accum = 64'd0; acc_m = 64'd0;
    endtask

    task automatic check_wb();
        check("wb_valid", {63'd0, wb_valid}, {63'd0, e_valid});
        check("wb_memtoreg", {63'd0, wb_memtoreg}, {63'd0, e_mtr});
        check("wb_acc", {63'd0, wb_acc}, {63'd0, e_acc});
        check("wb_regwrite", {63'd0, wb_regwrite}, {63'd0, e_rw});
        check("wb_rd", {59'd0, wb_rd}, {59'd0, e_rd});
        check("wb_read_data", {32'd0, wb_read_data}, {32'd0, e_rdata});
        check("wb_alu_res", {32'd0, wb_alu_res}, {32'd0, e_alu});
        check("wb_accumulator", wb_accumulator, e_accum);
        check("misalign", {63'd0, misalign}, {63'd0, e_mis});
    endtask

    // Drive one instruction from EX; memory answers after nwait wait states.
    // Called at posedge+1, returns at posedge+1 after the instruction leaves.
    task automatic txn(input logic mr, input logic mw, input logic rw, input logic mtr,
                       input logic ac, input logic clr, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                       input int nwait, input logic [63:0] prod);
        logic memop, mis, hs, accop;
        int   cyc;
        int   stalls;
        memop  = mr | mw;
        mis    = memop && (a[1:0] != 2'b00);
        hs     = memop && !mis;
        cyc    = hs ? nwait + 1 : 1;
        stalls = 0;
        ex_valid = 1'b1; memread = mr; memwrite = mw; regwrite = rw; memtoreg = mtr;
        acc = ac; rd = r; alu_res = a; store_data = sd; mac_product = prod;
        for (int k = 0; k < cyc; k++) begin
            dmem_ready = hs ? (k == nwait) : 1'($urandom_range(0, 1));
            dmem_rdata = (hs && k == nwait) ? rdat : $urandom;
            acc_clr    = (k == cyc - 1) ? clr : 1'b0;
            #3;
            check("dmem_req", {63'd0, dmem_req}, {63'd0, hs});
            if (hs) begin
                check("dmem_we", {63'd0, dmem_we}, {63'd0, mw});
                check("dmem_addr", {32'd0, dmem_addr}, {32'd0, a});
                check("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, sd});
            end
            if (mem_stall) stalls++;
            @(posedge clk); #1;
        end
        check("stall_cycles", 64'(stalls), hs ? 64'(nwait) : 64'd0);
        accop = ac && !memop;
        if (clr) acc_m = accop ? prod : 64'd0;
        else if (accop) acc_m = acc_m + prod;
        if (!mis) begin
            e_valid = 1'b1; e_mtr = mtr; e_acc = ac; e_rd = r; e_alu = a;
            e_rw = rw && !(memop && mw);
            if (memop && mr && !mw) e_rdata = rdat;
            if (accop) e_accum = acc_m;
        end else begin
            e_valid = 1'b0;
        end
        e_mis = mis;
        acc_clr = 1'b0;
        check_wb();
    endtask

    // A cycle with no valid instruction; stray ready must be ignored
    task automatic idle();
        ex_valid = 1'b0;
        memread = 1'($urandom_range(0, 1)); memwrite = 1'($urandom_range(0, 1));
        acc = 1'($urandom_range(0, 1)); alu_res = $urandom;
        dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom; acc_clr = 1'b0;
        #3;
        check("idle_req", {63'd0, dmem_req}, 64'd0);
        check("idle_stall", {63'd0, mem_stall}, 64'd0);
        @(posedge clk); #1;
        e_valid = 1'b0; e_mis = 1'b0;
        check_wb();
    endtask

    logic        r_mr, r_mw;
    logic [31:0] r_a;
    int          kind;

    initial begin
        rst = 1'b1; ex_valid = 1'b1; alu_res = 32'h100; store_data = 32'd0;
        memread = 1'b1; memwrite = 1'b0; memtoreg = 1'b0; regwrite = 1'b0; acc = 1'b0;
        rd = 5'd0; mac_product = 64'd0; acc_clr = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        #3;
        check("rst_req", {63'd0, dmem_req}, 64'd0);
        check("rst_stall", {63'd0, mem_stall}, 64'd0);
        @(posedge clk); #1;
        check_wb();
        rst = 1'b0;

        // Directed scenarios
        txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 0, 64'd0);
        txn(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2, 64'd0);
        check("load_data", {32'd0, wb_read_data}, 64'h0000_0000_DEAD_BEEF);
        txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0200, 32'hA5A5_A5A5, 32'd0, 0, 64'd0);
        txn(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0103, 32'd0, 32'h1111_2222, 0, 64'd0);
        idle();
        txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'd0, 32'd0, 32'd0, 0, 64'h7FFF_FFFF_FFFF_FFFF);
        txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'd0, 32'd0, 32'd0, 0, 64'd2);
        check("mac_wrap", wb_accumulator, 64'h8000_0000_0000_0001);
        txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'd0, 32'd0, 32'd0, 0, 64'd5);
        check("mac_clr", wb_accumulator, 64'd5);

        // Reset in the middle of a stalled load
        ex_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; alu_res = 32'h300;
        dmem_ready = 1'b0; acc = 1'b0;
        #3;
        check("pre_rst_stall", {63'd0, mem_stall}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        check("wait_rst_req", {63'd0, dmem_req}, 64'd0);
        check("wait_rst_stall", {63'd0, mem_stall}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_wb();
        txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h40, 32'd0, 32'd0, 0, 64'd7);
        check("acc_after_rst", wb_accumulator, 64'd7);
        txn(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h0000_0400, 32'd0, 32'hCAFE_F00D, 0, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) idle();
            kind = $urandom_range(0, 3);
            r_mr = (kind == 1) || (kind == 3);
            r_mw = (kind == 2) || (kind == 3);
            r_a  = $urandom;
            if ($urandom_range(0, 3) != 0) r_a[1:0] = 2'b00;
            txn(r_mr, r_mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                5'($urandom_range(0, 31)), r_a, $urandom, $urandom,
                $urandom_range(0, 3), {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
